// File: rtl/shift_seq_pkg.sv
// Shared types for the shift-register command sequencer.
//   op_t    : command opcodes (5..7 are NOP)
//   mode_t  : register mode as {l,r}
//   state_t : sequencer FSM states
package shift_seq_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD = 3'd0,
    OP_SHU  = 3'd1,
    OP_SHD  = 3'd2,
    OP_ROTU = 3'd3,
    OP_ROTD = 3'd4,
    OP_NOP5 = 3'd5,
    OP_NOP6 = 3'd6,
    OP_NOP7 = 3'd7
  } op_t;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// Command handshake bus between the command source and the sequencer.
//   cmd_valid/cmd_ready : one command per handshake
//   cmd_op              : operation (op_t)
//   cmd_amount          : number of shift cycles
//   cmd_fill            : serial fill bit for SHU/SHD
//   cmd_data            : load value for LOAD
interface shift_seq_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  op_t           cmd_op;
  logic [CW-1:0] cmd_amount;
  logic          cmd_fill;
  logic [W-1:0]  cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_amount, cmd_fill, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amount, cmd_fill, cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/shift_seq.sv
// Command sequencer for a W-bit universal shift register.
// Accepts one command per handshake, expands it into RUN cycles that drive
// the register mode {l,r}, serial input i and load data d, then pulses done.
//   clk, nrst      : clock, async active-low reset
//   cmd            : command handshake bus (slave side)
//   q_in           : register contents fed back (used for rotation/ser_out)
//   l, r, i, d     : register mode, serial input, parallel load data
//   ser_out/valid  : bit leaving the register in the current shift cycle
//   busy, done     : not-idle flag, one-cycle completion pulse
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         nrst,
  shift_seq_if.slave   cmd,
  input  logic [W-1:0] q_in,
  output logic         l,
  output logic         r,
  output logic         i,
  output logic [W-1:0] d,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done
);

  state_t        r_state;
  op_t           r_op;
  logic          r_fill;
  logic [W-1:0]  r_data;
  logic [CW-1:0] r_count;

  state_t        w_state_nxt;
  op_t           w_op_nxt;
  logic          w_fill_nxt;
  logic [W-1:0]  w_data_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_amt_clamp;
  mode_t         w_mode;
  logic          w_ready;

  // Shift amounts beyond the register width are clamped to W cycles
  assign w_amt_clamp = (cmd.cmd_amount > CW'(W)) ? CW'(W) : cmd.cmd_amount;

  // State and command latches
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_NOP5;
      r_fill  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_fill  <= w_fill_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state and mode/serial outputs
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_fill_nxt  = r_fill;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_mode      = MODE_HOLD;
    w_ready     = 1'b0;
    i           = 1'b0;
    d           = '0;
    ser_out     = 1'b0;
    ser_valid   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        busy    = 1'b0;
        w_ready = 1'b1;
        if (cmd.cmd_valid) begin
          w_op_nxt   = cmd.cmd_op;
          w_fill_nxt = cmd.cmd_fill;
          w_data_nxt = cmd.cmd_data;
          case (cmd.cmd_op)
            OP_LOAD:                           w_count_nxt = CW'(1);
            OP_SHU, OP_SHD, OP_ROTU, OP_ROTD:  w_count_nxt = w_amt_clamp;
            default:                           w_count_nxt = '0;
          endcase
          w_state_nxt = (w_count_nxt == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        w_count_nxt = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_nxt = ST_DONE;
        end
        case (r_op)
          OP_LOAD: begin
            w_mode = MODE_LOAD;
            d      = r_data;
          end
          OP_SHU: begin
            w_mode    = MODE_UP;
            i         = r_fill;
            ser_out   = q_in[W-1];
            ser_valid = 1'b1;
          end
          OP_SHD: begin
            w_mode    = MODE_DOWN;
            i         = r_fill;
            ser_out   = q_in[0];
            ser_valid = 1'b1;
          end
          // Rotation feeds the outgoing bit straight back in as the fill
          OP_ROTU: begin
            w_mode    = MODE_UP;
            i         = q_in[W-1];
            ser_out   = q_in[W-1];
            ser_valid = 1'b1;
          end
          OP_ROTD: begin
            w_mode    = MODE_DOWN;
            i         = q_in[0];
            ser_out   = q_in[0];
            ser_valid = 1'b1;
          end
          default: w_mode = MODE_HOLD;
        endcase
      end

      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign {l, r}        = w_mode;
  assign cmd.cmd_ready = w_ready;

endmodule

// File: doc/shift_seq.md
# shift_seq

Command sequencer for the W-bit universal shift register (hold / shift up / shift down / parallel load, selected by `l`,`r`). It accepts one command per handshake, expands it into a timed sequence of mode cycles, drives `l`, `r`, `i` and `d`, and reports completion. It also exposes the bit shifted out of the register as a serial stream. It sits between the bus/CPU-side command source and the register instance, and reads back the register's `q` to implement rotation.

## Interface

**Parameters**
- `W`, default 8: register width.
- `CW`, default `$clog2(W+1)`: width of the shift amount.

**Ports**
- `clk` in 1: clock; the register and the sequencer both update on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the sequencer can accept a command (high only in IDLE).
- `cmd_op` in 3: operation, one of the `op_t` values.
- `cmd_amount` in CW: number of shift cycles.
- `cmd_fill` in 1: serial fill bit for SHU/SHD.
- `cmd_data` in W: load value for LOAD.
- `q_in` in W: current register contents, fed back from the register.
- `l`, `r` out 1 each: register mode. 00 = hold; 01 = up (`q[k]<=q[k-1]`, `q[0]<=i`); 10 = down (`q[k]<=q[k+1]`, `q[W-1]<=i`); 11 = load `d`.
- `i` out 1: serial input to the register.
- `d` out W: parallel load data.
- `ser_out` out 1: the bit leaving the register in the current shift cycle.
- `ser_valid` out 1: `ser_out` is meaningful this cycle.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse marking command completion.

## Operation

**Operations (`op_t`)**
- LOAD = 0
- SHU = 1
- SHD = 2
- ROTU = 3
- ROTD = 4
- Codes 5–7 are NOP.

**State machine**
- States are IDLE, RUN and DONE.
- IDLE: the command is accepted on `cmd_valid && cmd_ready`. On acceptance the sequencer latches op, fill and data, and loads count.
  - count = 1 for LOAD.
  - count = min(`cmd_amount`, W) for shift and rotate ops.
  - count = 0 for NOP.
- Transitions out of IDLE: count == 0 goes to DONE; otherwise goes to RUN.
- RUN: drives the mode for the latched op and decrements count each cycle. It goes to DONE after the cycle in which count == 1.
- DONE: `done` = 1 for exactly one cycle, then the state returns to IDLE.

**Outputs in RUN**
- LOAD: `{l,r}` = 11, `d` = latched data.
- SHU: `{l,r}` = 01, `i` = fill, `ser_out` = `q_in[W-1]`.
- SHD: `{l,r}` = 10, `i` = fill, `ser_out` = `q_in[0]`.
- ROTU: `{l,r}` = 01, `i` = `q_in[W-1]`, `ser_out` = `q_in[W-1]`.
- ROTD: `{l,r}` = 10, `i` = `q_in[0]`, `ser_out` = `q_in[0]`.
- `ser_valid` = 1 during RUN for shift and rotate ops only.

**Outside RUN**
- `{l,r}` = 00; `i`, `d` and `ser_out` = 0; `ser_valid` = 0.

**Ordering**
- No command is accepted while `busy`, so `cmd_*` is ignored in RUN and DONE.
- `cmd_valid` may be held high across a command; the next command is accepted in the first IDLE cycle.

**Reset**
- Asserting `nrst` at any time, including mid-RUN, forces IDLE immediately and asynchronously.
- Reset values: `{l,r}` = 00, `i` = 0, `d` = 0, `ser_out` = 0, `ser_valid` = 0, `busy` = 0, `done` = 0, `cmd_ready` = 1.
- A shift sequence cut short by reset leaves the register holding whatever it reached. It is not rolled back.

## Timing

- Cycle 0: acceptance edge.
- Cycles 1..N: RUN, where N = count. The register updates at the end of each RUN cycle.
- Cycle N+1: DONE. `done` = 1 and the final `q_in` is visible.
- Cycle N+2: IDLE, `cmd_ready` = 1.
- Throughput is one command per N+2 cycles. A NOP or amount 0 takes 2 cycles (accept, DONE).
- `l`, `r`, `i`, `d`, `ser_*`, `busy` and `cmd_ready` are combinational from registered state plus `q_in`. There is no extra pipeline stage between the sequencer and the register.

## Structure

- Package `shift_seq_pkg`:
  - `op_t` (3-bit enum, values above).
  - `mode_t` (2-bit enum {l,r}: HOLD, UP, DOWN, LOAD).
  - `state_t` (IDLE, RUN, DONE).
- One module, no sub-modules.
- The test bench instantiates the existing 8-bit universal shift register as the load and wires its `q` to `q_in`.

## Test plan

- **Reset mid-RUN:** after accepting SHU amount 5, drop `nrst` in cycle 2. Outputs go immediately to `{l,r}` = 00, `busy` = 0, `cmd_ready` = 1, `done` = 0. No `done` pulse follows.
- **LOAD:** LOAD 0xA5. One cycle of `{l,r}` = 11 with `d` = 0xA5. `q` = 0xA5 and `done` = 1 in cycle 2; `cmd_ready` = 1 in cycle 3.
- **SHU with fill:** from `q` = 0xA5, SHU amount 3, fill 1. Three cycles of mode 01. `ser_out` sequence is 1, 0, 1. Final `q` = 0x2F; `done` in cycle 4.
- **Rotate:** from `q` = 0x3C, ROTD amount 4. Final `q` = 0xC3. ROTU amount 8 on 0x81 gives 0x81.
- **Clamp and amount 0:** from 0xFF, SHD amount 12, fill 0. Exactly 8 shift cycles; `q` = 0x00. Then SHU amount 0: `done` in cycle 1, no non-hold mode cycles, `q` unchanged.
- **Back-to-back:** hold `cmd_valid` high with LOAD 0x0F, then SHU amount 2 fill 0. `cmd_ready` is low for cycles 1–2. The second command is accepted in cycle 3. Final `q` = 0x3C.
